uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL provide baud_rate_control  input  16  clock cycles per serial bit, sampled at frame start.
REQ-004 SHALL provide tx_data  input  8  byte to transmit, qualified by tx_valid.
REQ-005 SHALL provide tx_valid  input  1  producer offers tx_data this cycle.
REQ-006 SHALL provide tx_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL provide data_line  output  1  serial line to the receiver, idle high, registered.
REQ-008 SHALL provide tx_busy  output  1  high while any frame bit (start, data or stop) is on data_line.

Function
REQ-009 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-010 SHALL accept a byte only on a cycle where tx_valid and tx_ready are both high; tx_data is ignored otherwise.
REQ-011 SHALL hold accepted bytes in a one-entry holding register; tx_ready = holding register empty.
REQ-012 SHALL run the FSM states IDLE, START, DATA and STOP.
REQ-013 IDLE -> START SHALL occur on the cycle after the holding register becomes full; the byte moves to the shift register and the holding register empties.
REQ-014 START -> DATA, DATA -> DATA (bit index 0..7) and DATA(bit 7) -> STOP SHALL occur on each bit-period terminal count.
REQ-015 STOP -> START (holding full) or STOP -> IDLE (holding empty) SHALL occur at the STOP terminal count, so back-to-back frames have zero idle gap.
REQ-016 Each bit SHALL last exactly P clock cycles, where P = the baud_rate_control value latched on entry to START.
REQ-017 If baud_rate_control < 4, P SHALL be clamped to 4, matching the receiver half-period minimum.
REQ-018 A change of baud_rate_control mid-frame SHALL NOT affect the frame in progress.
REQ-019 Latency SHALL be: byte accepted in cycle N from IDLE -> data_line falls at cycle N+2; frame occupies exactly 10*P cycles.
REQ-020 Acceptance in the same cycle as the holding-to-shift transfer SHALL be allowed; the new byte refills the holding register with no loss.
REQ-021 data_line SHALL be 1 in IDLE; tx_busy SHALL be 0 only in IDLE.
REQ-022 The bit-period counter SHALL count 0..P-1, wrap to 0 at the terminal count, and be held at 0 in IDLE.

Reset
REQ-023 On reset assertion, data_line=1, tx_ready=1 and tx_busy=0 SHALL take effect immediately without a clock edge.
REQ-024 On reset assertion, the FSM SHALL go to IDLE and the holding register, shift register, bit index and period counter SHALL clear.
REQ-025 Reset mid-frame SHALL abort the frame; the partial byte and any held byte SHALL be discarded.
REQ-026 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-027 The state encoding, DATA_BITS=8 and MIN_BAUD=4 SHALL live in shared package uart_pkg, which the receiver uses as well.
REQ-028 Bit timing SHALL be a sub-module uart_baud_tick (counter with load of P, enable and a terminal-count pulse).
REQ-029 All outputs SHALL be driven from registers; no combinational path from tx_valid to data_line.

Verification
REQ-030 P=16, send 0x55 -> start low 16 cycles, bits 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16; total 160 cycles.
REQ-031 0xA3 then 0x3C with tx_valid held -> tx_ready drops while holding is full; second start bit begins the cycle after the first stop ends.
REQ-032 baud_rate_control=2, send 0xFF -> every bit lasts 4 cycles; frame is 40 cycles.
REQ-033 Reset during data bit 3 of 0x0F -> data_line=1 and tx_ready=1 before the next edge; after release, 0x81 transmits cleanly.
REQ-034 baud_rate_control changed 16 -> 32 mid-frame -> current frame keeps 16-cycle bits; next frame uses 32.
REQ-035 Loopback into UART_RX with baud_rate_control=16, send 0xC5 -> receiver read_buffer = 0xC5 after the stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver
package uart_pkg;

    localparam int          DATA_BITS = 8;
    localparam logic [15:0] MIN_BAUD  = 16'd4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Bit periods below MIN_BAUD would leave the receiver no valid half-period
    function automatic logic [15:0] clamp_period(input logic [15:0] p);
        return (p < MIN_BAUD) ? MIN_BAUD : p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter with period load, enable and terminal-count pulse
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] period,
    output logic        tc
);

    logic [15:0] per;
    logic [15:0] cnt;

    assign tc = en && (cnt == per - 16'd1);

    // Latch the clamped period on load; count 0..per-1 while enabled, hold 0 otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per <= MIN_BAUD;
            cnt <= '0;
        end else begin
            if (load)
                per <= clamp_period(period);
            cnt <= (load || !en || tc) ? '0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry holding register
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_rate_control,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        data_line,
    output logic        tx_busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] hold_data;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_idx;
    logic                 tc;
    logic                 accept;
    logic                 xfer;

    assign accept = tx_valid && tx_ready;
    // Holding register feeds the shifter when idle or when a stop bit completes
    assign xfer   = !tx_ready && (state == IDLE || (state == STOP && tc));

    uart_baud_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .load   (xfer),
        .en     (state != IDLE),
        .period (baud_rate_control),
        .tc     (tc)
    );

    // Holding register; tx_ready is its registered empty flag, refillable during a transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ready  <= 1'b1;
            hold_data <= '0;
        end else begin
            if (accept)
                hold_data <= tx_data;
            tx_ready <= !(accept || (!tx_ready && !xfer));
        end
    end

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            bit_idx   <= '0;
            data_line <= 1'b1;
            tx_busy   <= 1'b0;
        end else if (xfer) begin
            state     <= START;
            shift     <= hold_data;
            bit_idx   <= '0;
            data_line <= 1'b0;
            tx_busy   <= 1'b1;
        end else if (tc) begin
            case (state)
                START: begin
                    state     <= DATA;
                    data_line <= shift[0];
                    shift     <= shift >> 1;
                    bit_idx   <= '0;
                end
                DATA: begin
                    state     <= (bit_idx == LAST_BIT) ? STOP : DATA;
                    data_line <= (bit_idx == LAST_BIT) ? 1'b1 : shift[0];
                    shift     <= shift >> 1;
                    bit_idx   <= bit_idx + 3'd1;
                end
                STOP: begin
                    state     <= IDLE;
                    data_line <= 1'b1;
                    tx_busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a cycle-exact line monitor/receiver
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         p;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] baud_rate_control = 16'd16;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        data_line;
    logic        tx_busy;

    exp_t       exp_q[$];
    int         starts[$];
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    int         frames = 0;
    int         acc_cyc = 0;
    logic [7:0] last_rx = 8'h00;

    uart_tx dut (
        .clk               (clk),
        .reset             (reset),
        .baud_rate_control (baud_rate_control),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .data_line         (data_line),
        .tx_busy           (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: on each falling start edge pop the expected frame, check every cycle, decode mid-bit
    initial begin
        logic       prev;
        logic       ok;
        logic       aborted;
        logic [9:0] bits;
        logic [7:0] rx;
        exp_t       e;
        int         bad_k;
        int         bad_c;
        logic       bad_line;
        logic       bad_busy;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev && !data_line) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame at cyc=%0d got start bit, required idle line", cyc);
                end else begin
                    e = exp_q.pop_front();
                    bits = {1'b1, e.data, 1'b0};
                    ok = 1'b1;
                    aborted = 1'b0;
                    rx = 8'h00;
                    bad_k = 0; bad_c = 0; bad_line = 1'b0; bad_busy = 1'b0;
                    for (int k = 0; k < 10 && !aborted; k++) begin
                        for (int c = 0; c < e.p && !aborted; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (reset) aborted = 1'b1;
                            else begin
                                if (c == e.p / 2 && k >= 1 && k <= 8) rx[k-1] = data_line;
                                if (ok && (data_line !== bits[k] || tx_busy !== 1'b1)) begin
                                    ok = 1'b0;
                                    bad_k = k; bad_c = c; bad_line = data_line; bad_busy = tx_busy;
                                end
                            end
                        end
                    end
                    if (!aborted) begin
                        checks++;
                        if (!ok) begin
                            fails++;
                            $display("FAIL frame_bits byte=%h bit=%0d cycle=%0d got line=%b busy=%b required line=%b busy=1",
                                     e.data, bad_k, bad_c, bad_line, bad_busy, bits[bad_k]);
                        end
                        checks++;
                        if (rx !== e.data) begin
                            fails++;
                            $display("FAIL rx_byte got %h required %h", rx, e.data);
                        end
                        last_rx = rx;
                        frames++;
                    end
                end
            end
            prev = data_line;
        end
    end

    // Offer a byte at the current falling edge and hold it until the handshake completes
    task automatic send(input logic [7:0] b, input int p);
        int n = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            fails++;
            $display("FAIL send_timeout byte=%h got tx_ready=%b required 1", b, tx_ready);
        end else begin
            exp_q.push_back('{b, p});
            acc_cyc = cyc;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (frames < n) begin
            fails++;
            $display("FAIL frame_timeout got %0d frames required %0d", frames, n);
        end
    endtask

    task automatic wait_idle(input int end_cyc);
        while (cyc < end_cyc) @(negedge clk);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        checks += 3;
        if (data_line !== 1'b1) begin fails++; $display("FAIL reset_line got %b required 1", data_line); end
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b required 1", tx_ready); end
        if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b required 0", tx_busy); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int n0 = starts.size();
        int f0 = frames;
        send(8'h55, 16);
        wait_frames(f0 + 1);
        if (starts.size() > n0) begin
            checks++;
            if (starts[n0] - acc_cyc !== 2) begin
                fails++;
                $display("FAIL start_latency got %0d required 2", starts[n0] - acc_cyc);
            end
            wait_idle(starts[n0] + 160);
            checks += 2;
            if (tx_busy !== 1'b0) begin fails++; $display("FAIL basic_end_busy got %b required 0", tx_busy); end
            if (data_line !== 1'b1) begin fails++; $display("FAIL basic_end_line got %b required 1", data_line); end
        end
    endtask

    task automatic test_back_to_back;
        int n0 = starts.size();
        int f0 = frames;
        send(8'hA3, 16);
        send(8'h3C, 16);
        checks++;
        if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_held got %b required 0", tx_ready); end
        wait_frames(f0 + 2);
        if (starts.size() > n0 + 1) begin
            checks++;
            if (starts[n0+1] - starts[n0] !== 160) begin
                fails++;
                $display("FAIL b2b_gap got %0d required 160", starts[n0+1] - starts[n0]);
            end
            wait_idle(starts[n0+1] + 161);
        end
    endtask

    task automatic test_min_baud;
        int n0 = starts.size();
        int f0 = frames;
        baud_rate_control = 16'd2;
        send(8'hFF, 4);
        wait_frames(f0 + 1);
        if (starts.size() > n0) begin
            wait_idle(starts[n0] + 40);
            checks++;
            if (tx_busy !== 1'b0) begin fails++; $display("FAIL min_baud_end_busy got %b required 0", tx_busy); end
        end
        baud_rate_control = 16'd16;
        @(negedge clk);
    endtask

    task automatic test_baud_change;
        int n0 = starts.size();
        int f0 = frames;
        baud_rate_control = 16'd16;
        send(8'h3C, 16);
        repeat (40) @(negedge clk);
        baud_rate_control = 16'd32;
        send(8'h5A, 32);
        wait_frames(f0 + 2);
        if (starts.size() > n0 + 1) begin
            checks++;
            if (starts[n0+1] - starts[n0] !== 160) begin
                fails++;
                $display("FAIL baud_change_first got %0d required 160", starts[n0+1] - starts[n0]);
            end
            wait_idle(starts[n0+1] + 320);
            checks++;
            if (tx_busy !== 1'b0) begin fails++; $display("FAIL baud_change_second_end got busy=%b required 0", tx_busy); end
        end
        baud_rate_control = 16'd16;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n0 = starts.size();
        int f0 = frames;
        int t = 0;
        send(8'h0F, 16);
        send(8'h77, 16);
        while (starts.size() <= n0 && t < 100) begin @(negedge clk); t++; end
        if (starts.size() > n0) begin
            wait_idle(starts[n0] + 72);
            #2 reset = 1'b1;
            #1;
            checks += 3;
            if (data_line !== 1'b1) begin fails++; $display("FAIL mid_reset_line got %b required 1", data_line); end
            if (tx_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b required 1", tx_ready); end
            if (tx_busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %b required 0", tx_busy); end
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(8'h81, 16);
        wait_frames(f0 + 1);
        repeat (200) @(negedge clk);
        checks++;
        if (starts.size() !== n0 + 2) begin
            fails++;
            $display("FAIL mid_reset_frames got %0d starts required %0d", starts.size() - n0, 2);
        end
    endtask

    task automatic test_loopback;
        int f0 = frames;
        send(8'hC5, 16);
        wait_frames(f0 + 1);
        checks++;
        if (last_rx !== 8'hC5) begin fails++; $display("FAIL loopback got %h required c5", last_rx); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_min_baud;
        test_baud_change;
        test_reset_mid;
        test_loopback;
        checks++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
